// File: rtl/lab1_mem_scrubber.sv
`default_nettype none
// ============================================================================
// Module   : lab1_mem_scrubber
// Brief    : Fills an on-chip memory region with a fixed or incrementing
//            pattern, or checks a region against that pattern and counts
//            the words that differ.
// Revision : 1.0
// ============================================================================
module lab1_mem_scrubber #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                mode,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     length,
    input  logic [DATA_W-1:0]   pattern,
    input  logic                incr,
    input  logic                abort,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [DATA_W/8-1:0] mem_byteenable,
    output logic                mem_chipselect,
    output logic                mem_write,
    output logic [DATA_W-1:0]   mem_writedata,
    output logic                mem_clken,
    input  logic [DATA_W-1:0]   mem_readdata,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W:0]     err_count,
    output logic [ADDR_W-1:0]   first_err_addr
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_CHECK = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [ADDR_W:0]   C_ONE     = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   C_ERR_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W-1:0] C_ADDR_1  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   pat_q, pat_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                incr_q, incr_d;
    logic                cmp_vld_q, cmp_vld_d;
    logic [DATA_W-1:0]   cmp_exp_q, cmp_exp_d;
    logic [ADDR_W-1:0]   cmp_addr_q, cmp_addr_d;
    logic [ADDR_W:0]     err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]   first_err_q, first_err_d;

    logic                w_access;
    logic                w_mismatch;
    logic [DATA_W-1:0]   w_pat_step;

    assign w_access   = (state_q == S_FILL) || (state_q == S_CHECK);
    assign w_mismatch = cmp_vld_q && (mem_readdata != cmp_exp_q);
    assign w_pat_step = {{(DATA_W-1){1'b0}}, incr_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            pat_q       <= '0;
            cnt_q       <= '0;
            incr_q      <= 1'b0;
            cmp_vld_q   <= 1'b0;
            cmp_exp_q   <= '0;
            cmp_addr_q  <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pat_q       <= pat_d;
            cnt_q       <= cnt_d;
            incr_q      <= incr_d;
            cmp_vld_q   <= cmp_vld_d;
            cmp_exp_q   <= cmp_exp_d;
            cmp_addr_q  <= cmp_addr_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pat_d       = pat_q;
        cnt_d       = cnt_q;
        incr_d      = incr_q;
        cmp_vld_d   = 1'b0;
        cmp_exp_d   = cmp_exp_q;
        cmp_addr_d  = cmp_addr_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;

        // The compare stage runs independently of the state, so the word
        // returning in the same cycle as an abort is still scored.
        if (w_mismatch) begin
            if (err_cnt_q != C_ERR_MAX) begin
                err_cnt_d = err_cnt_q + C_ONE;
            end
            if (err_cnt_q == '0) begin
                first_err_d = cmp_addr_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    addr_d      = base_addr;
                    pat_d       = pattern;
                    cnt_d       = length;
                    incr_d      = incr;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    if (length == '0) begin
                        state_d = S_DONE;
                    end else if (mode) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                addr_d = addr_q + C_ADDR_1;
                pat_d  = pat_q + w_pat_step;
                cnt_d  = cnt_q - C_ONE;
                if (cnt_q == C_ONE) begin
                    state_d = S_DONE;
                end
            end
            S_CHECK: begin
                addr_d     = addr_q + C_ADDR_1;
                pat_d      = pat_q + w_pat_step;
                cnt_d      = cnt_q - C_ONE;
                cmp_vld_d  = 1'b1;
                cmp_exp_d  = pat_q;
                cmp_addr_d = addr_q;
                if (cnt_q == C_ONE) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A read still in flight when aborting is dropped, not scored.
        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            cmp_vld_d = 1'b0;
        end
    end

    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
    assign mem_chipselect = w_access;
    assign mem_write      = (state_q == S_FILL);
    assign mem_address    = w_access ? addr_q : '0;
    assign mem_writedata  = (state_q == S_FILL) ? pat_q : '0;
    assign mem_byteenable = '1;
    assign mem_clken      = 1'b1;
    assign err_count      = err_cnt_q;
    assign first_err_addr = first_err_q;

endmodule
`default_nettype wire

// File: tb/tb_lab1_mem_scrubber.sv
`default_nettype none
// ============================================================================
// Module   : tb_lab1_mem_scrubber
// Brief    : Directed vector bench for lab1_mem_scrubber with a 1-cycle memory.
// Revision : 1.0
// ============================================================================
module tb_lab1_mem_scrubber;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        mode;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic [31:0] pattern;
    logic        incr;
    logic        abort;
    logic [9:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic [31:0] mem_readdata;
    logic        busy;
    logic        done;
    logic [10:0] err_count;
    logic [9:0]  first_err_addr;

    logic        poke_en;
    logic [9:0]  poke_addr;
    logic [31:0] poke_data;
    logic [31:0] mem [0:1023];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lab1_mem_scrubber #(.ADDR_W(10), .DATA_W(32)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .mode           (mode),
        .base_addr      (base_addr),
        .length         (length),
        .pattern        (pattern),
        .incr           (incr),
        .abort          (abort),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .mem_readdata   (mem_readdata),
        .busy           (busy),
        .done           (done),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

    // Ideal synchronous memory: read data appears one cycle after the address.
    always @(posedge clk) begin
        if (poke_en) begin
            mem[poke_addr] <= poke_data;
        end else if (mem_chipselect && mem_write) begin
            mem[mem_address] <= mem_writedata;
        end
        mem_readdata <= mem[mem_address];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        op_mode;
        logic [9:0]  op_base;
        logic [10:0] op_len;
        logic [31:0] op_pat;
        logic        op_incr;
        logic        hold_start;
        logic        poke5;
        int          exp_done;
        logic [10:0] exp_err;
        logic [9:0]  exp_first;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int          done_at;
        int          n_acc;
        int          bad_seq;
        int          n_cs;
        int          n_done;
        logic [9:0]  ea;
        logic [31:0] ed;

        vecs[0] = '{1'b0, 10'd0,    11'd16, 32'h0000_1000, 1'b1, 1'b0, 1'b0, 17, 11'd0,  10'd0};
        vecs[1] = '{1'b1, 10'd0,    11'd16, 32'h0000_1000, 1'b1, 1'b0, 1'b0, 18, 11'd0,  10'd0};
        vecs[2] = '{1'b1, 10'd0,    11'd16, 32'h0000_1000, 1'b1, 1'b0, 1'b1, 18, 11'd1,  10'd5};
        vecs[3] = '{1'b0, 10'd1020, 11'd8,  32'hA5A5_A5A5, 1'b0, 1'b1, 1'b0, 9,  11'd0,  10'd0};
        vecs[4] = '{1'b1, 10'd1020, 11'd8,  32'hA5A5_A5A5, 1'b0, 1'b0, 1'b0, 10, 11'd0,  10'd0};
        vecs[5] = '{1'b1, 10'd0,    11'd16, 32'h0000_2000, 1'b1, 1'b0, 1'b0, 18, 11'd16, 10'd0};
        vecs[6] = '{1'b0, 10'd0,    11'd0,  32'h1234_5678, 1'b1, 1'b1, 1'b0, 1,  11'd0,  10'd0};

        reset = 1'b1; start = 1'b0; mode = 1'b0; base_addr = '0; length = '0;
        pattern = '0; incr = 1'b0; abort = 1'b0;
        poke_en = 1'b0; poke_addr = '0; poke_data = '0;
        start = 1'b1;
        repeat (3) tick();
        check("rst_busy_done", {busy, done}, 2'b00);
        check("rst_cs_wr", {mem_chipselect, mem_write}, 2'b00);
        check("rst_addr_wdata", {mem_address, mem_writedata}, 42'd0);
        check("rst_be_clken", {mem_byteenable, mem_clken}, 5'b11111);
        check("rst_err", {err_count, first_err_addr}, 21'd0);
        start = 1'b0;
        reset = 1'b0;
        tick();
        check("idle_after_rst", {busy, done, mem_chipselect}, 3'b000);

        for (int v = 0; v < 7; v++) begin
            if (vecs[v].poke5) begin
                poke_en = 1'b1; poke_addr = 10'd5; poke_data = 32'hDEAD_BEEF;
                tick();
                poke_en = 1'b0;
            end
            mode = vecs[v].op_mode; base_addr = vecs[v].op_base; length = vecs[v].op_len;
            pattern = vecs[v].op_pat; incr = vecs[v].op_incr;
            start = 1'b1;
            tick();
            if (!vecs[v].hold_start) start = 1'b0;
            done_at = -1; n_acc = 0; bad_seq = 0;
            for (int k = 1; k <= int'(vecs[v].op_len) + 10; k++) begin
                if (!busy) bad_seq++;
                if (mem_chipselect) begin
                    ea = vecs[v].op_base + n_acc[9:0];
                    ed = vecs[v].op_incr ? vecs[v].op_pat + n_acc : vecs[v].op_pat;
                    if (k != n_acc + 1 || mem_address !== ea || mem_write !== ~vecs[v].op_mode
                        || mem_byteenable !== 4'hF
                        || (!vecs[v].op_mode && mem_writedata !== ed)) bad_seq++;
                    n_acc++;
                end
                if (done) begin
                    done_at = k;
                    break;
                end
                tick();
            end
            start = 1'b0;
            check($sformatf("v%0d_done_cycle", v), done_at, vecs[v].exp_done);
            check($sformatf("v%0d_access_count", v), n_acc, vecs[v].op_len);
            check($sformatf("v%0d_access_seq", v), bad_seq, 0);
            check($sformatf("v%0d_err_count", v), err_count, vecs[v].exp_err);
            check($sformatf("v%0d_first_err", v), first_err_addr, vecs[v].exp_first);
            tick();
            check($sformatf("v%0d_idle_after", v), {busy, done, mem_chipselect}, 3'b000);
            check($sformatf("v%0d_err_hold", v), {err_count, first_err_addr},
                  {vecs[v].exp_err, vecs[v].exp_first});
        end

        // Abort on the 4th cycle of a 16-word fill.
        mode = 1'b0; base_addr = 10'd100; length = 11'd16; pattern = 32'h0000_3000; incr = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_cs = 0; n_done = 0;
        for (int k = 1; k <= 24; k++) begin
            if (mem_chipselect) n_cs++;
            if (done) n_done++;
            if (k == 5) check("fill_abort_idle", {busy, mem_chipselect, mem_write}, 3'b000);
            abort = (k == 4);
            tick();
        end
        check("fill_abort_accesses", n_cs, 4);
        check("fill_abort_no_done", n_done, 0);
        check("fill_abort_mem103", mem[103], 32'h0000_3003);

        // Abort mid-check: compares of reads 1..3 count, read 4 is dropped.
        mode = 1'b1; base_addr = 10'd0; length = 11'd16; pattern = 32'h0000_2000; incr = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_done = 0;
        for (int k = 1; k <= 10; k++) begin
            if (done) n_done++;
            abort = (k == 4);
            tick();
        end
        check("check_abort_partial_err", err_count, 11'd3);
        check("check_abort_state", {busy, n_done[0], mem_chipselect}, 3'b000);

        // Abort and start together in IDLE: start is ignored.
        mode = 1'b0; start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("abort_beats_start", {busy, mem_chipselect}, 2'b00);
        check("abort_start_err_kept", err_count, 11'd3);

        // Reset in the middle of a check.
        mode = 1'b1; base_addr = 10'd0; length = 11'd16; pattern = 32'h0000_1000; incr = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("midrst_before_busy", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst_state", {busy, done, mem_chipselect, mem_write}, 4'b0000);
        check("midrst_outputs", {mem_address, mem_writedata, mem_byteenable}, {42'd0, 4'hF});
        check("midrst_err", {err_count, first_err_addr}, 21'd0);
        n_cs = 0; n_done = 0;
        for (int k = 0; k < 20; k++) begin
            if (mem_chipselect) n_cs++;
            if (done) n_done++;
            tick();
        end
        check("midrst_quiet", {n_cs[7:0], n_done[7:0]}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lab1_mem_scrubber.md
LAB1_MEM_SCRUBBER -- requirements
Module: lab1_mem_scrubber

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning the word-address width of the downstream on-chip memory.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the data width, fixed at 32 with byteenable width DATA_W/8.
REQ-003 The block SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The block SHALL have port start, input, 1, a one-cycle request sampled only in IDLE.
REQ-006 The block SHALL have port mode, input, 1, where 0 means fill and 1 means check.
REQ-007 The block SHALL have port base_addr, input, ADDR_W, the first word address.
REQ-008 The block SHALL have port length, input, ADDR_W+1, a word count from 0 to 1024.
REQ-009 The block SHALL have port pattern, input, DATA_W, the seed value.
REQ-010 The block SHALL have port incr, input, 1, where 1 gives the pattern for word i as pattern+i mod 2^32 and 0 gives a constant pattern.
REQ-011 The block SHALL have port abort, input, 1, a synchronous cancel.
REQ-012 The block SHALL have port mem_address, output, ADDR_W, the memory address.
REQ-013 The block SHALL have port mem_byteenable, output, 4, the memory byte enables.
REQ-014 The block SHALL have port mem_chipselect, output, 1, the memory chip select.
REQ-015 The block SHALL have port mem_write, output, 1, the memory write strobe.
REQ-016 The block SHALL have port mem_writedata, output, DATA_W, the memory write data.
REQ-017 The block SHALL have port mem_clken, output, 1, the memory clock enable.
REQ-018 The block SHALL have port mem_readdata, input, DATA_W, the memory read data, valid exactly 1 cycle after the address is presented.
REQ-019 The block SHALL have port busy, output, 1, high whenever the block is not IDLE.
REQ-020 The block SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-021 The block SHALL have port err_count, output, ADDR_W+1, the number of check mismatches.
REQ-022 The block SHALL have port first_err_addr, output, ADDR_W, the address of the first mismatch.

Function
REQ-023 The FSM SHALL have exactly the states IDLE, FILL, CHECK, DRAIN and DONE.
REQ-024 In IDLE with start=1, the block SHALL latch mode, base_addr, length, pattern and incr, clear err_count and first_err_addr, and go to FILL (mode=0) or CHECK (mode=1).
REQ-025 If length=0 at start, the block SHALL go straight to DONE with no memory access.
REQ-026 The block SHALL ignore start while it is not in IDLE.
REQ-027 In FILL, the block SHALL drive one write per cycle (chipselect=1, write=1, byteenable=4'hF) with address base+i mod 2^ADDR_W and writedata = pattern word i, for i = 0..length-1.
REQ-028 After the last FILL write, the block SHALL go to DONE.
REQ-029 In CHECK, the block SHALL issue one read per cycle (chipselect=1, write=0) for i = 0..length-1, then go to DRAIN for 1 cycle, then go to DONE.
REQ-030 Each cycle after a read issue, the block SHALL compare mem_readdata with the expected word, carried in a 1-deep pipeline register together with its address.
REQ-031 On a mismatch, the block SHALL increment err_count, saturating at 1024.
REQ-032 On the first mismatch of an operation, the block SHALL capture first_err_addr.
REQ-033 The address SHALL wrap 1023->0 without error.
REQ-034 For length=1024 the block SHALL cover every word exactly once.
REQ-035 Latency SHALL be as follows, with start sampled at cycle T: first access at T+1; FILL done at T+1+length; CHECK done at T+2+length; length=0 done at T+1.
REQ-036 DONE SHALL last 1 cycle with done=1 and busy=1, then return to IDLE.
REQ-037 err_count and first_err_addr SHALL hold their values until the next accepted start.
REQ-038 mem_clken SHALL be constant 1.
REQ-039 Outside FILL and CHECK, mem_chipselect and mem_write SHALL be 0.
REQ-040 In any non-IDLE state, abort=1 SHALL force IDLE on the next edge with no done pulse and no further accesses from that edge, and err_count SHALL keep its partial value.
REQ-041 If abort and start are both 1 in IDLE, abort SHALL win and the start SHALL be ignored.
REQ-042 A mismatch compared in the same cycle abort is seen SHALL still be counted.

Reset
REQ-043 reset=1 SHALL take priority over all other inputs and put the block in IDLE on the next clk edge.
REQ-044 During and after reset, the outputs SHALL be: busy=0, done=0, mem_chipselect=0, mem_write=0, mem_address=0, mem_writedata=0, mem_byteenable=4'hF, err_count=0, first_err_addr=0.
REQ-045 Reset asserted mid-operation SHALL abandon the operation without a done pulse.

Verification
REQ-046 The bench SHALL cover this scenario: fill with base=0, length=16, pattern=0x1000, incr=1 -> writes to addresses 0..15 with data 0x1000..0x100F on cycles T+1..T+16, and done at T+17.
REQ-047 The bench SHALL cover this scenario: check of the same region against an ideal 1-cycle memory model -> done at T+18, err_count=0.
REQ-048 The bench SHALL cover this scenario: corrupt word 5 to 0xDEADBEEF, then check with base=0, length=16 -> err_count=1, first_err_addr=5.
REQ-049 The bench SHALL cover this scenario: fill with base=1020, length=8, incr=0, pattern=0xA5A5A5A5 -> addresses 1020..1023 then 0..3, and done at T+9.
REQ-050 The bench SHALL cover this scenario: length=0 start -> done at T+1, no chipselect, err_count=0; and start held during busy -> ignored.
REQ-051 The bench SHALL cover this scenario: abort at the 4th cycle of a 16-word fill, and separately reset mid-check -> IDLE on the next edge, no done, chipselect=0, busy=0.
